// File: rtl/priority_arbiter_8.sv
// ---------------------------------------------------------------------------
// priority_arbiter_8
//   Eight-way arbiter with a single owner at a time. A winner is chosen in
//   IDLE, either by fixed priority (highest index wins) or round-robin
//   (search descends from one below the previous owner, wrapping 0 -> 7).
//   The owner keeps the grant until it signals done, withdraws its request,
//   arbitration is disabled, or its tenure reaches MAX_HOLD cycles. Every
//   release passes through one IDLE cycle before the next grant.
//
// Parameters
//   MAX_HOLD : maximum grant tenure in clock cycles (2..255)
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   en       : arbitration enable
//   mode     : 0 = fixed priority, 1 = round-robin (sampled in IDLE only)
//   req[7:0] : request lines, one per requester
//   done     : current owner releases the grant
//   gnt[7:0] : registered one-hot grant
//   gnt_id   : registered binary index of the owner
//   busy     : high while a grant is held
//   timeout  : one-cycle pulse after a release caused only by MAX_HOLD
// ---------------------------------------------------------------------------
module priority_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       mode,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] last_id;
    logic [7:0] hold_cnt;

    // Index of the highest set bit of v (0 when v is empty).
    function automatic logic [2:0] highest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Round-robin: rotate req so that the search start (last_id - 1) lands
    // on bit 7, then a plain highest-set search gives the descending,
    // wrapping order. Adding the rotation back recovers the real index.
    logic [2:0] rr_start;
    logic [7:0] rr_rot;
    logic [2:0] rr_id;
    logic [2:0] win_id;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        rr_start = last_id - 3'd1;
        rr_rot   = '0;
        for (int j = 0; j < 8; j++) begin
            rr_rot[j] = req[3'(rr_start + 3'd1 + 3'(j))];
        end
        rr_id  = rr_start + 3'd1 + highest_set(rr_rot);
        win_id = mode ? rr_id : highest_set(req);
    end

    logic hold_done;
    logic release_now;

    assign hold_done   = (hold_cnt == 8'(MAX_HOLD - 1));
    assign release_now = done || !req[gnt_id] || !en || hold_done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            last_id  <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (en && (req != 8'd0)) begin
                        state    <= GRANT;
                        gnt      <= 8'd1 << win_id;
                        gnt_id   <= win_id;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        gnt    <= '0;
                        gnt_id <= '0;
                        busy   <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        busy    <= 1'b0;
                        last_id <= gnt_id;
                        // Only flag a timeout when nothing else ended the tenure.
                        timeout <= hold_done && !done && req[gnt_id] && en;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                        timeout  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    gnt_id  <= '0;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priority_arbiter_8.sv
// ---------------------------------------------------------------------------
// tb_priority_arbiter_8
//   Self-checking bench: directed scenarios with literal expectations, then
//   randomized traffic. A behavioural model tracks the owner as an integer
//   and is compared with the DUT outputs on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_priority_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] req = 8'd0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_total = 0;
    int n_pass  = 0;

    priority_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int owner   = -1;   // -1 when no grant is held
    int hold    = 0;    // cycles already spent in the current tenure
    int last    = 0;    // previous owner
    bit m_tmo   = 1'b0;

    function automatic int pick_winner(input logic [7:0] r, input logic m, input int prev);
        if (!m) begin
            for (int i = 7; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (prev - 1 - k + 16) % 8;
                if (r[idx]) return idx;
            end
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = -1; hold = 0; last = 0; m_tmo = 1'b0;
        end else if (owner < 0) begin
            m_tmo = 1'b0;
            if (en && req != 8'd0) begin
                owner = pick_winner(req, mode, last);
                hold  = 0;
            end
        end else begin
            bit expired, other;
            expired = (hold + 1 >= MAX_HOLD);
            other   = done || !req[owner] || !en;
            m_tmo   = 1'b0;
            if (expired || other) begin
                m_tmo = expired && !other;
                last  = owner;
                owner = -1;
            end else begin
                hold++;
            end
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        check("gnt",     {24'd0, gnt},     (owner < 0) ? 32'd0 : (32'd1 << owner));
        check("gnt_id",  {29'd0, gnt_id},  (owner < 0) ? 32'd0 : 32'(owner));
        check("busy",    {31'd0, busy},    {31'd0, owner >= 0});
        check("timeout", {31'd0, timeout}, {31'd0, m_tmo});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("reset_gnt",  {24'd0, gnt}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        rst_n = 1'b1;

        // Fixed priority and done-driven regrant.
        mode = 1'b0; en = 1'b1; req = 8'b1010_0100;
        tick();
        check("fix_gnt", {24'd0, gnt}, 32'h80);
        check("fix_id",  {29'd0, gnt_id}, 32'd7);
        done = 1'b1;
        tick();
        check("fix_gap", {24'd0, gnt}, 32'h0);
        done = 1'b0;
        tick();
        check("fix_regrant", {24'd0, gnt}, 32'h80);
        req = 8'd0;
        tick();
        tick();

        // Round-robin from reset.
        do_reset();
        mode = 1'b1; req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("rr_id", {29'd0, gnt_id}, 32'((7 - k + 8) % 8));
            check("rr_busy", {31'd0, busy}, 32'd1);
            done = 1'b1;
            tick();
            check("rr_gap", {24'd0, gnt}, 32'h0);
            done = 1'b0;
        end
        req = 8'd0;
        tick();
        tick();

        // Tenure limit.
        mode = 1'b0; req = 8'h08;
        for (int k = 0; k < MAX_HOLD; k++) begin
            tick();
            check("hold_gnt", {24'd0, gnt}, 32'h08);
        end
        tick();
        check("tmo_pulse", {31'd0, timeout}, 32'd1);
        check("tmo_gnt",   {24'd0, gnt}, 32'h0);
        tick();
        check("tmo_regrant", {24'd0, gnt}, 32'h08);
        check("tmo_clear",   {31'd0, timeout}, 32'd0);
        req = 8'd0;
        tick();
        tick();

        // Withdrawal, then enable drop.
        req = 8'h21;
        tick();
        check("wd_id", {29'd0, gnt_id}, 32'd5);
        req = 8'h01;
        tick();
        check("wd_busy", {31'd0, busy}, 32'd0);
        check("wd_tmo",  {31'd0, timeout}, 32'd0);
        tick();
        check("wd_next", {24'd0, gnt}, 32'h01);
        en = 1'b0;
        tick();
        check("en_rel", {31'd0, busy}, 32'd0);
        tick();
        tick();
        check("en_hold", {24'd0, gnt}, 32'h0);
        en = 1'b1;
        req = 8'd0;
        tick();

        // done coinciding with the last allowed cycle.
        req = 8'h08;
        for (int k = 0; k < MAX_HOLD; k++) tick();
        done = 1'b1;
        tick();
        check("sim_busy", {31'd0, busy}, 32'd0);
        check("sim_tmo",  {31'd0, timeout}, 32'd0);
        done = 1'b0;
        req = 8'd0;
        tick();

        // Asynchronous reset mid-grant.
        req = 8'h10;
        tick();
        check("ar_pre", {24'd0, gnt}, 32'h10);
        #2 rst_n = 1'b0;
        #1;
        check("ar_gnt",  {24'd0, gnt}, 32'h0);
        check("ar_id",   {29'd0, gnt_id}, 32'h0);
        check("ar_busy", {31'd0, busy}, 32'h0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            en   = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) req = 8'($urandom) & 8'($urandom);
            done = ($urandom_range(0, 9) == 0);
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/priority_arbiter_8.md
PRIORITY_ARBITER_8 -- requirements
Module: priority_arbiter_8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum grant tenure in clock cycles (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: arbitration enable.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = fixed priority, 1 = round-robin.
REQ-006 The block SHALL have port req, input, 8 bits: one request line per requester, index 7..0.
REQ-007 The block SHALL have port done, input, 1 bit: the current owner releases the grant.
REQ-008 The block SHALL have port gnt, output, 8 bits: one-hot grant, registered.
REQ-009 The block SHALL have port gnt_id, output, 3 bits: binary index of the granted requester, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a grant is held.
REQ-011 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-012 The block SHALL implement two states, IDLE and GRANT; busy SHALL be 1 exactly in GRANT.
REQ-013 In IDLE with en=1 and req!=0, the next edge SHALL enter GRANT with gnt/gnt_id set to the winner; latency from req to gnt is 1 cycle.
REQ-014 In IDLE with en=0 or req=0, the block SHALL stay in IDLE with gnt=0 and gnt_id=0.
REQ-015 Fixed mode: the winner SHALL be the highest set index of req (req[7] highest, req[0] lowest).
REQ-016 Round-robin mode: the search SHALL start at index (last_id-1) mod 8 and descend with wrap from 0 to 7; the first set bit wins.
REQ-017 last_id SHALL be a 3-bit register loaded with gnt_id on every release and reset to 0, so the first round-robin search starts at 7.
REQ-018 mode SHALL be sampled only in IDLE; a change of mode during GRANT SHALL NOT affect the current grant.
REQ-019 gnt SHALL be one-hot in GRANT, all-zero in IDLE, and consistent with gnt_id at every cycle.
REQ-020 A hold counter (8 bits) SHALL clear on entry to GRANT and increment on each GRANT cycle.
REQ-021 In GRANT, any of the following SHALL cause a release at the next edge: done=1; req[gnt_id]=0; en=0; hold counter == MAX_HOLD-1.
REQ-022 On release the block SHALL return to IDLE for at least one cycle with gnt=0, so back-to-back grants always have a one-cycle gap.
REQ-023 timeout SHALL be 1 for exactly the first IDLE cycle after a release caused solely by the hold counter; it SHALL be 0 if done=1, req[gnt_id]=0 or en=0 in the same cycle.
REQ-024 A granted tenure SHALL last at most MAX_HOLD cycles.
REQ-025 Requests from other indices SHALL NOT pre-empt an active grant in either mode.

Reset
REQ-026 With rst_n=0, outputs SHALL go immediately and asynchronously to gnt=0, gnt_id=0, busy=0, timeout=0; state SHALL be IDLE, last_id=0, hold counter=0.
REQ-027 An assertion of rst_n during GRANT SHALL abort the grant immediately; after rst_n deasserts, the first arbitration SHALL occur on the first edge with en=1 and req!=0.

Verification
REQ-028 Reset: drive rst_n=0 mid-grant (gnt=8'h10) -> gnt=0, gnt_id=0, busy=0 within the same cycle, without waiting for a clock edge.
REQ-029 Fixed priority: mode=0, en=1, req=8'b1010_0100 -> next cycle gnt=8'h80, gnt_id=7; pulse done -> one cycle of gnt=0, then gnt=8'h80 again.
REQ-030 Round-robin: mode=1, req=8'hFF held, done pulsed once per grant -> gnt_id sequence 7,6,5,4,3,2,1,0,7, with one idle cycle between grants.
REQ-031 Timeout: MAX_HOLD=4, req=8'h08 held, done=0 -> busy for 4 cycles, timeout=1 for one cycle with gnt=0, then gnt=8'h08 re-granted.
REQ-032 Withdrawal and enable: in GRANT with gnt_id=5, drop req[5] -> release next edge with timeout=0; in a separate grant, drop en -> release, no regrant while en=0.
REQ-033 Simultaneous events: done=1 in the same cycle the hold counter reaches MAX_HOLD-1 -> release with timeout=0.
